// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types used by the L1/L2 arbiter.
package lc3b_types;

    // Byte-offset bits inside one L2 line; bit (L2_OFFSET_BITS-1) picks the half.
    localparam int L2_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2,
        RESP   = 2'd3
    } lc3b_arb_state;

    typedef logic [1:0] lc3b_l2_wmask;

    // Half-line write enable for an L1 line landing in the upper or lower L2 half.
    function automatic lc3b_l2_wmask half_mask(input logic upper);
        return upper ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/l1_l2_arbiter_line_buffer.sv
// l2_line_buffer: one-entry cache of the last L2 read line (tag, valid, data).
// Only present when L1L2_LINE_BUFFER_EN is defined; otherwise this file is empty.
`ifdef L1L2_LINE_BUFFER_EN
module l2_line_buffer
    import lc3b_types::*;
#(
    parameter int TAG_W     = 11,
    parameter int L1_LINE_W = 128,
    parameter int L2_LINE_W = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fill_en,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [L2_LINE_W-1:0] fill_data,
    input  logic                 wr_en,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic                 wr_upper,
    input  logic [L1_LINE_W-1:0] wr_data,
    input  logic [TAG_W-1:0]     lookup_tag,
    input  logic                 lookup_upper,
    output logic                 hit,
    output logic [L1_LINE_W-1:0] hit_data
);
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [L2_LINE_W-1:0] line;

    // Entry update: a completed L2 read replaces the entry; a D write to the
    // buffered line patches the addressed half so the entry never goes stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            line  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            line  <= fill_data;
        end else if (wr_en && valid && (wr_tag == tag)) begin
            if (wr_upper)
                line[L2_LINE_W-1:L1_LINE_W] <= wr_data;
            else
                line[L1_LINE_W-1:0] <= wr_data;
        end
    end

    assign hit      = valid && (lookup_tag == tag);
    assign hit_data = lookup_upper ? line[L2_LINE_W-1:L1_LINE_W] : line[L1_LINE_W-1:0];

endmodule
`endif

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: serves 128-bit I-cache and D-cache line requests from a
// 256-bit L2, D-cache first. Defining L1L2_LINE_BUFFER_EN adds a one-entry
// line buffer that answers repeat reads without an L2 access.
module l1_l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W    = 16,
    parameter int L1_LINE_W = 128,
    parameter int L2_LINE_W = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ic_read,
    input  logic [ADDR_W-1:0]    ic_address,
    output logic [L1_LINE_W-1:0] ic_rdata,
    output logic                 ic_resp,
    input  logic                 dc_read,
    input  logic                 dc_write,
    input  logic [ADDR_W-1:0]    dc_address,
    input  logic [L1_LINE_W-1:0] dc_wdata,
    output logic [L1_LINE_W-1:0] dc_rdata,
    output logic                 dc_resp,
    output logic                 l2_read,
    output logic                 l2_write,
    output logic [ADDR_W-1:0]    l2_address,
    output logic [L2_LINE_W-1:0] l2_wdata,
    output logic [1:0]           l2_wmask,
    input  logic [L2_LINE_W-1:0] l2_rdata,
    input  logic                 l2_resp
);
    localparam int TAG_W    = ADDR_W - L2_OFFSET_BITS;
    localparam int HALF_BIT = L2_OFFSET_BITS - 1;

    lc3b_arb_state        state, next_state;
    logic [ADDR_W-1:0]    addr_q;
    logic [L1_LINE_W-1:0] wdata_q;
    logic                 owner_d;
    logic                 d_req, req_any, req_write, in_busy;
    logic [ADDR_W-1:0]    req_addr;
    logic                 buf_hit;
    logic [L1_LINE_W-1:0] buf_half, l2_half;
    logic                 unused_addr_bits;

    assign d_req     = dc_read | dc_write;
    assign req_any   = d_req | ic_read;
    // Both D strobes high is a protocol error; the write wins.
    assign req_write = d_req & dc_write;
    assign req_addr  = d_req ? dc_address : ic_address;
    assign in_busy   = (state == D_BUSY) || (state == I_BUSY);
    assign l2_half   = addr_q[HALF_BIT] ? l2_rdata[L2_LINE_W-1:L1_LINE_W]
                                        : l2_rdata[L1_LINE_W-1:0];

`ifdef L1L2_LINE_BUFFER_EN
    logic raw_hit;

    l2_line_buffer #(
        .TAG_W     (TAG_W),
        .L1_LINE_W (L1_LINE_W),
        .L2_LINE_W (L2_LINE_W)
    ) u_line_buffer (
        .clk          (clk),
        .reset_n      (reset_n),
        .fill_en      (in_busy && l2_resp && l2_read),
        .fill_tag     (addr_q[ADDR_W-1:L2_OFFSET_BITS]),
        .fill_data    (l2_rdata),
        .wr_en        ((state == IDLE) && req_write),
        .wr_tag       (dc_address[ADDR_W-1:L2_OFFSET_BITS]),
        .wr_upper     (dc_address[HALF_BIT]),
        .wr_data      (dc_wdata),
        .lookup_tag   (req_addr[ADDR_W-1:L2_OFFSET_BITS]),
        .lookup_upper (req_addr[HALF_BIT]),
        .hit          (raw_hit),
        .hit_data     (buf_half)
    );

    assign buf_hit = (state == IDLE) && req_any && !req_write && raw_hit;
`else
    assign buf_hit  = 1'b0;
    assign buf_half = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state: grant in IDLE (buffer hits skip L2), wait for L2, one resp cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_any)
                    next_state = buf_hit ? RESP : (d_req ? D_BUSY : I_BUSY);
            end
            D_BUSY, I_BUSY: begin
                if (l2_resp)
                    next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch at grant, registered L2 strobes, and read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_d  <= 1'b0;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            ic_rdata <= '0;
            dc_rdata <= '0;
        end else if ((state == IDLE) && req_any) begin
            addr_q   <= req_addr;
            owner_d  <= d_req;
            l2_read  <= !buf_hit && !req_write;
            l2_write <= req_write;
            if (d_req)
                wdata_q <= dc_wdata;
            if (buf_hit) begin
                if (d_req)
                    dc_rdata <= buf_half;
                else
                    ic_rdata <= buf_half;
            end
        end else if (in_busy && l2_resp) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            // Writes return no line for the requester; only reads update rdata.
            if (l2_read) begin
                if (owner_d)
                    dc_rdata <= l2_half;
                else
                    ic_rdata <= l2_half;
            end
        end
    end

    assign dc_resp    = (state == RESP) && owner_d;
    assign ic_resp    = (state == RESP) && !owner_d;
    assign l2_address = {addr_q[ADDR_W-1:L2_OFFSET_BITS], {L2_OFFSET_BITS{1'b0}}};
    assign l2_wdata   = {wdata_q, wdata_q};
    assign l2_wmask   = l2_write ? half_mask(addr_q[HALF_BIT]) : 2'b00;

    // Byte offset within a half-line is irrelevant to line transfers.
    assign unused_addr_bits = ^addr_q[HALF_BIT-1:0];

endmodule
